// File: rtl/switch_event_pkg.sv
// -----------------------------------------------------------------------------
// switch_event_pkg
// Shared definitions for the switch event decoder:
//   - state_t   : decoder FSM states (IDLE, SHORT, LONG)
//   - EV_*      : event codes stored in the event register
//   - max_u32   : helper used to size the counter bound check
// -----------------------------------------------------------------------------
package switch_event_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam logic [1:0] EV_SHORT  = 2'd0;
    localparam logic [1:0] EV_LONG   = 2'd1;
    localparam logic [1:0] EV_REPEAT = 2'd2;

    function automatic logic [31:0] max_u32(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/switch_event_latch.sv
// -----------------------------------------------------------------------------
// switch_event_latch
// Single-entry event register polled by slow bus-side logic.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   short_ev          : short-press strobe (loads EV_SHORT)
//   long_ev           : long-press strobe (loads EV_LONG)
//   repeat_ev         : auto-repeat strobe (loads EV_REPEAT)
//   event_ack         : consume the pending event
//   event_valid       : an unacknowledged event is held
//   event_code        : type of the held event
//   event_overrun     : sticky, an event replaced an unacknowledged one
// -----------------------------------------------------------------------------
module switch_event_latch
    import switch_event_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       short_ev,
    input  logic       long_ev,
    input  logic       repeat_ev,
    input  logic       event_ack,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       event_overrun
);

    logic       new_ev;
    logic [1:0] new_code;

    // The decoder never raises two of these in the same cycle; the priority
    // only exists to keep the mux fully specified.
    always_comb begin
        new_ev = short_ev | long_ev | repeat_ev;
        if (short_ev) begin
            new_code = EV_SHORT;
        end else if (long_ev) begin
            new_code = EV_LONG;
        end else begin
            new_code = EV_REPEAT;
        end
    end

    // A new event always wins the register. An ack arriving in the same
    // cycle counts as consuming the old event, so no overrun is flagged and
    // the flag is cleared as any ack of a valid event would.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_valid   <= 1'b0;
            event_code    <= EV_SHORT;
            event_overrun <= 1'b0;
        end else if (new_ev) begin
            event_code  <= new_code;
            event_valid <= 1'b1;
            if (event_valid && !event_ack) begin
                event_overrun <= 1'b1;
            end else if (event_valid && event_ack) begin
                event_overrun <= 1'b0;
            end
        end else if (event_valid && event_ack) begin
            event_valid   <= 1'b0;
            event_overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/switch_event_decoder.sv
// -----------------------------------------------------------------------------
// switch_event_decoder
// Turns a debounced switch level into press/release strobes, short/long press
// classification and (optionally) auto-repeat, and latches the classified
// events into a valid/ack event register.
// Optional feature: define SWITCH_EVENT_REPEAT_EN to build the auto-repeat
// logic; without it repeat_strb is tied low and the counter holds in LONG.
// Parameters:
//   LONG_DELAY   : cycles a press must last to count as long (>= 1)
//   REPEAT_DELAY : cycles between repeat events once long (>= 1)
//   ACTIVE_HIGH  : switch level meaning "pressed"
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   switch_in     : debounced switch level, synchronous to clk
//   press_strb    : one-cycle pulse on press
//   release_strb  : one-cycle pulse on release
//   short_press   : pulse on release of a press shorter than LONG_DELAY
//   long_press    : pulse when a press reaches LONG_DELAY
//   repeat_strb   : pulse every REPEAT_DELAY while long-held
//   held          : FSM is in SHORT or LONG
//   event_valid   : event register holds an unacknowledged event
//   event_code    : 0 short, 1 long, 2 repeat
//   event_overrun : sticky overwrite flag, cleared by ack
//   event_ack     : consume the current event
// -----------------------------------------------------------------------------
module switch_event_decoder
    import switch_event_pkg::*;
#(
    parameter logic [31:0] LONG_DELAY   = 32'h04_00_00_00,
    parameter logic [31:0] REPEAT_DELAY = 32'h01_00_00_00,
    parameter logic        ACTIVE_HIGH  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch_in,
    output logic       press_strb,
    output logic       release_strb,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_strb,
    output logic       held,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       event_overrun,
    input  logic       event_ack
);

    localparam logic [31:0] CNT_LIMIT = max_u32(LONG_DELAY, REPEAT_DELAY);

    logic        sw_q;
    logic        pressed;
    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic        press_d;
    logic        release_d;
    logic        short_d;
    logic        long_d;

    // Resetting to the released level means a switch held through reset is
    // seen as a fresh press once reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q <= ~ACTIVE_HIGH;
        end else begin
            sw_q <= switch_in;
        end
    end

    assign pressed = (sw_q == ACTIVE_HIGH);

    // State and counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. Release is tested first so it beats a long or repeat
    // threshold falling in the same cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (pressed) begin
                    state_next = SHORT;
                end
            end
            SHORT: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == LONG_DELAY - 32'd1) begin
                    state_next = LONG;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            LONG: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
`ifdef SWITCH_EVENT_REPEAT_EN
                else if (cnt == REPEAT_DELAY - 32'd1) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
`endif
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Strobe decode, registered below together with the state transition so
    // each strobe lines up with the cycle the new state becomes visible.
    always_comb begin
        press_d   = (state == IDLE) && pressed;
        release_d = (state != IDLE) && !pressed;
        short_d   = (state == SHORT) && !pressed;
        long_d    = (state == SHORT) && pressed && (cnt == LONG_DELAY - 32'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_strb   <= 1'b0;
            release_strb <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            press_strb   <= press_d;
            release_strb <= release_d;
            short_press  <= short_d;
            long_press   <= long_d;
        end
    end

`ifdef SWITCH_EVENT_REPEAT_EN
    logic repeat_d;
    logic repeat_q;

    always_comb begin
        repeat_d = (state == LONG) && pressed && (cnt == REPEAT_DELAY - 32'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign repeat_strb = repeat_q;
`else
    assign repeat_strb = 1'b0;
`endif

    assign held = (state != IDLE);

    switch_event_latch u_latch (
        .clk           (clk),
        .reset         (reset),
        .short_ev      (short_press),
        .long_ev       (long_press),
        .repeat_ev     (repeat_strb),
        .event_ack     (event_ack),
        .event_valid   (event_valid),
        .event_code    (event_code),
        .event_overrun (event_overrun)
    );

    // The counter is cleared at every threshold, so it stays below the
    // larger of the two delays.
    cnt_bound_a: assert property (@(posedge clk) disable iff (reset) cnt < CNT_LIMIT);

endmodule

// File: tb/tb_switch_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_switch_event_decoder
// Directed bench for switch_event_decoder with LONG_DELAY=8, REPEAT_DELAY=4.
// Each step drives inputs, waits one rising edge and samples 1 time unit later.
// Repeat expectations follow SWITCH_EVENT_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_switch_event_decoder;

`ifdef SWITCH_EVENT_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    typedef struct packed {
        logic       press;
        logic       rel;
        logic       shrt;
        logic       lng;
        logic       rpt;
        logic       held;
        logic       valid;
        logic [1:0] code;
        logic       ovr;
    } out_t;

    typedef struct {
        logic sw;
        logic ack;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       switch_in = 1'b0;
    logic       event_ack = 1'b0;
    logic       press_strb;
    logic       release_strb;
    logic       short_press;
    logic       long_press;
    logic       repeat_strb;
    logic       held;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_overrun;

    int checks = 0;
    int failures = 0;

    switch_event_decoder #(
        .LONG_DELAY   (32'd8),
        .REPEAT_DELAY (32'd4),
        .ACTIVE_HIGH  (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .switch_in     (switch_in),
        .press_strb    (press_strb),
        .release_strb  (release_strb),
        .short_press   (short_press),
        .long_press    (long_press),
        .repeat_strb   (repeat_strb),
        .held          (held),
        .event_valid   (event_valid),
        .event_code    (event_code),
        .event_overrun (event_overrun),
        .event_ack     (event_ack)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and sample just after the next rising edge.
    task automatic applyStimulus(input logic sw, input logic ack);
        switch_in = sw;
        event_ack = ack;
        @(posedge clk);
        #1;
    endtask

    // Compare the whole output vector in one go.
    task automatic checkOutput(input string tag, input out_t exp);
        out_t act;
        act = {press_strb, release_strb, short_press, long_press, repeat_strb,
               held, event_valid, event_code, event_overrun};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%b expected=%b (press rel short long rpt held valid code ovr)",
                     tag, act, exp);
        end
    endtask

    vec_t tbl[13];
    out_t e;
    int   o;

    initial begin
        // Two short presses with no ack, then an ack.
        //                    p r s l rp h v cc o
        tbl[0]  = '{1'b1, 1'b0, 10'b0_0_0_0_0_0_0_00_0};
        tbl[1]  = '{1'b1, 1'b0, 10'b1_0_0_0_0_1_0_00_0};
        tbl[2]  = '{1'b1, 1'b0, 10'b0_0_0_0_0_1_0_00_0};
        tbl[3]  = '{1'b0, 1'b0, 10'b0_0_0_0_0_1_0_00_0};
        tbl[4]  = '{1'b0, 1'b0, 10'b0_1_1_0_0_0_0_00_0};
        tbl[5]  = '{1'b0, 1'b0, 10'b0_0_0_0_0_0_1_00_0};
        tbl[6]  = '{1'b1, 1'b0, 10'b0_0_0_0_0_0_1_00_0};
        tbl[7]  = '{1'b1, 1'b0, 10'b1_0_0_0_0_1_1_00_0};
        tbl[8]  = '{1'b0, 1'b0, 10'b0_0_0_0_0_1_1_00_0};
        tbl[9]  = '{1'b0, 1'b0, 10'b0_1_1_0_0_0_1_00_0};
        tbl[10] = '{1'b0, 1'b0, 10'b0_0_0_0_0_0_1_00_1};
        tbl[11] = '{1'b0, 1'b1, 10'b0_0_0_0_0_0_0_00_0};
        tbl[12] = '{1'b0, 1'b0, 10'b0_0_0_0_0_0_0_00_0};

        // Reset state.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("reset_%0d", i), 10'b0);
        end
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_reset_idle", 10'b0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].sw, tbl[i].ack);
            checkOutput($sformatf("table_%0d", i), tbl[i].exp);
        end

        // Long hold of 20 cycles; release coincides with a repeat threshold.
        for (int r = 0; r < 23; r++) begin
            o = r - 1;
            applyStimulus(r < 20, 1'b0);
            e       = '0;
            e.press = (o == 0);
            e.lng   = (o == 8);
            e.rpt   = REP && ((o == 12) || (o == 16));
            e.rel   = (o == 20);
            e.held  = (o >= 0) && (o < 20);
            e.valid = (o >= 9);
            e.code  = (o < 9) ? 2'd0 : ((REP && (o >= 13)) ? 2'd2 : 2'd1);
            e.ovr   = REP && (o >= 13);
            checkOutput($sformatf("hold_%0d", r), e);
        end
        applyStimulus(1'b0, 1'b1);
        e      = '0;
        e.code = REP ? 2'd2 : 2'd1;
        checkOutput("hold_ack", e);

        // Short press left pending, then ack lands with the long_press.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 3, 1'b0);
        end
        checkOutput("pend_short", 10'b0_0_0_0_0_0_1_00_0);
        for (int r = 0; r < 15; r++) begin
            applyStimulus(r < 12, r == 10);
            if (r == 9)  checkOutput("ackcoll_long",  10'b0_0_0_1_0_1_1_00_0);
            if (r == 10) checkOutput("ackcoll_load",  10'b0_0_0_0_0_1_1_01_0);
            if (r == 13) checkOutput("ackcoll_rel",   10'b0_1_0_0_0_0_1_01_0);
            if (r == 14) checkOutput("ackcoll_after", 10'b0_0_0_0_0_0_1_01_0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("ackcoll_clear", 10'b0_0_0_0_0_0_0_01_0);

        // Reset asserted mid-press with the switch still held.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("midhold_held", 10'b0_0_0_0_0_1_0_01_0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("midhold_reset_%0d", i), 10'b0);
        end
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rearm_0", 10'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rearm_press", 10'b1_0_0_0_0_1_0_00_0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rearm_held", 10'b0_0_0_0_0_1_0_00_0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rearm_release", 10'b0_1_1_0_0_0_0_00_0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rearm_event", 10'b0_0_0_0_0_0_1_00_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_event_decoder.md
# switch_event_decoder

Consumes the debounced switch level from the debouncer and turns it into discrete user events: press/release strobes, short-press and long-press classification, and optional auto-repeat while held. Events are also latched into a single-entry event register with a valid/ack handshake so that slow bus-side logic can poll and acknowledge them. It sits directly downstream of the debouncer, between the front-panel switch path and the monitor's register interface.

## Interface
Parameters:
- LONG_DELAY, 32'h04_00_00_00, cycles a press must last to be classified long; legal range is 1 or more.
- REPEAT_DELAY, 32'h01_00_00_00, cycles between repeat events once long; legal range is 1 or more.
- ACTIVE_HIGH, 1, switch level that means "pressed" (1 or 0).

Ports:
- clk, in, 1, single clock; all logic is rising-edge.
- reset, in, 1, synchronous, active-high reset.
- switch_in, in, 1, debounced switch level, already synchronous to clk.
- press_strb, out, 1, one-cycle pulse on press.
- release_strb, out, 1, one-cycle pulse on release.
- short_press, out, 1, one-cycle pulse on release of a press shorter than LONG_DELAY.
- long_press, out, 1, one-cycle pulse when a press reaches LONG_DELAY.
- repeat_strb, out, 1, one-cycle pulse per REPEAT_DELAY while long-held; tied to 0 without the macro.
- held, out, 1, high while the FSM is in the SHORT or LONG state.
- event_valid, out, 1, event register holds an unacknowledged event.
- event_code, out, 2, event type: 0 is short, 1 is long, 2 is repeat; 3 is reserved.
- event_overrun, out, 1, sticky flag: an event overwrote an unacknowledged one.
- event_ack, in, 1, pulse to consume the current event.

## Operation
- switch_in is registered once into sw_q. That register resets to the released level (!ACTIVE_HIGH). pressed = (sw_q == ACTIVE_HIGH).
- FSM states are IDLE, SHORT and LONG. A 32-bit counter cnt is cleared on every state change.
- IDLE:
  - On pressed: assert press_strb, set cnt to 0, go to SHORT.
- SHORT (cnt increments every cycle):
  - On !pressed: assert release_strb and short_press, go to IDLE.
  - Otherwise, when cnt == LONG_DELAY-1: assert long_press, set cnt to 0, go to LONG.
- LONG:
  - On !pressed: assert release_strb only (no short_press), go to IDLE.
  - With repeat enabled: cnt increments; when cnt == REPEAT_DELAY-1, assert repeat_strb and set cnt to 0.
- Release always wins over a simultaneous long or repeat threshold in the same cycle.
- Event register:
  - short_press, long_press and repeat_strb each load event_code and set event_valid.
  - event_ack while event_valid clears event_valid and event_overrun.
  - A new event while event_valid && !event_ack overwrites event_code and sets event_overrun.
  - A new event coinciding with event_ack loads the new code, leaves event_valid = 1, and does not set event_overrun.
  - event_ack while !event_valid is ignored.
- Reset values: every output is 0, state is IDLE, cnt is 0, sw_q is the released level.
- Reset mid-press aborts the press with no release or short event. If the switch is still pressed after reset, a fresh press_strb follows.

## Timing
- All outputs are registered.
- switch_in changes before edge k. It is sampled into sw_q at edge k, and the strobe is high in the cycle after edge k+1. That is 2 cycles of latency from switch_in.
- If press_strb is high in cycle t, long_press is high in cycle t+LONG_DELAY.
- The first repeat_strb is high in cycle t+LONG_DELAY+REPEAT_DELAY, then every REPEAT_DELAY cycles after that.
- event_valid and event_code update in the cycle after the corresponding strobe.
- cnt never exceeds max(LONG_DELAY, REPEAT_DELAY)-1. No wrap-around is possible.

## Configuration
- SWITCH_EVENT_REPEAT_EN:
  - Defined: the LONG-state counter and repeat_strb generation are compiled in, and code 2 events are produced.
  - Undefined: repeat_strb is tied to 0, cnt holds in LONG, REPEAT_DELAY is unused, and event_code never takes the value 2.

## Structure
- Package switch_event_pkg holds:
  - the FSM state encoding (IDLE, SHORT, LONG);
  - the event code constants EV_SHORT=0, EV_LONG=1, EV_REPEAT=2.
- One sub-module, switch_event_latch, implements the event register, overrun flag and ack logic. The FSM and counter live in the top module.

## Test plan
Use LONG_DELAY=8 and REPEAT_DELAY=4 for all scenarios.
- Press for 3 cycles, then release:
  - press_strb is high 2 cycles after the press.
  - release_strb and short_press are high 2 cycles after the release.
  - event_code=0 and event_valid=1.
- Hold for 20 cycles with repeat enabled:
  - long_press fires 8 cycles after press_strb.
  - repeat_strb fires at +12 and +16.
  - The release produces release_strb only.
- Same hold with the macro undefined: long_press only, repeat_strb never asserted, event_code=1.
- Two short presses with no ack, then an ack:
  - event_overrun=1 after the second press.
  - The ack clears both event_valid and event_overrun.
- event_ack in the same cycle as a new long_press: event_valid stays 1, event_code=1, event_overrun=0.
- Reset asserted mid-hold, then released with switch_in still pressed:
  - All outputs are 0 during reset.
  - press_strb fires 2 cycles after reset deasserts.
  - No short_press is generated for the aborted press.
